// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: one-to-four handshaked demultiplexer, explicit or TDM slot select.
// Optional per-channel beat counters enabled by defining TDM_DEMUX_BEAT_CNT_EN.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic             auto_en,
    input  logic             sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       slot
`ifdef TDM_DEMUX_BEAT_CNT_EN
    ,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b,
    output logic [7:0]       cnt_c,
    output logic [7:0]       cnt_d
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } slot_e;

    slot_e            r_slot;
    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;

    logic [1:0]       w_tgt;
    logic             w_acc;
    logic [3:0]       w_wr;

    // Target channel: frame sync pins TDM mode to slot 0 for this cycle.
    always_comb begin
        w_tgt = {s1, s0};
        if (auto_en) begin
            w_tgt = sync ? 2'd0 : r_slot;
        end
    end

    assign in_ready = ~r_valid[w_tgt] | out_ready[w_tgt];
    assign w_acc    = in_valid & in_ready;
    assign w_wr     = w_acc ? (4'b0001 << w_tgt) : 4'b0000;

    // Per-channel holding buffers; a fill wins over a drain so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (r_valid[i] && out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Slot FSM: advances past the target on accept, sync alone rewinds to S0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= S0;
        end else if (auto_en) begin
            if (w_acc) begin
                r_slot <= slot_e'(w_tgt + 2'd1);
            end else if (sync) begin
                r_slot <= S0;
            end
        end
    end

    assign out_a     = r_data[0];
    assign out_b     = r_data[1];
    assign out_c     = r_data[2];
    assign out_d     = r_data[3];
    assign out_valid = r_valid;
    assign slot      = r_slot;

`ifdef TDM_DEMUX_BEAT_CNT_EN
    logic [7:0] r_cnt [4];
    logic       w_frame;

    assign w_frame = auto_en & sync;

    // Saturating accepted-beat counters, restarted by a TDM frame sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr[i]) begin
                    if (w_frame) begin
                        r_cnt[i] <= 8'd1;
                    end else if (r_cnt[i] != 8'hFF) begin
                        r_cnt[i] <= r_cnt[i] + 8'd1;
                    end
                end else if (w_frame) begin
                    r_cnt[i] <= 8'd0;
                end
            end
        end
    end

    assign cnt_a = r_cnt[0];
    assign cnt_b = r_cnt[1];
    assign cnt_c = r_cnt[2];
    assign cnt_d = r_cnt[3];
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: scoreboard bench for tdm_demux_4ch, directed plus random traffic.
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;
    logic       auto_en = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'b0000;
    logic [1:0] slot;
`ifdef TDM_DEMUX_BEAT_CNT_EN
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q [4][$];
    bit         occ [4];
    int         exp_slot = 0;

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .s0(s0), .s1(s1), .auto_en(auto_en), .sync(sync),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_valid(out_valid), .out_ready(out_ready), .slot(slot)
`ifdef TDM_DEMUX_BEAT_CNT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] chan_data(int i);
        case (i)
            0: return out_a;
            1: return out_b;
            2: return out_c;
            default: return out_d;
        endcase
    endfunction

    function automatic logic [3:0] occ_vec();
        return {occ[3], occ[2], occ[1], occ[0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            occ[i] = 1'b0;
            q[i].delete();
        end
        exp_slot = 0;
    endtask

    // One clock of stimulus: drive, check state against the model, advance model.
    task automatic cycle(bit iv, logic [7:0] d, bit au, logic [1:0] sel,
                         bit sy, logic [3:0] ordy);
        int tgt;
        bit rdy;
        bit acc;
        @(negedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        auto_en   = au;
        {s1, s0}  = sel;
        sync      = sy;
        out_ready = ordy;
        #1;
        tgt = au ? (sy ? 0 : exp_slot) : int'(sel);
        rdy = !occ[tgt] || ordy[tgt];
        acc = iv && rdy;
        chk("out_valid", out_valid, occ_vec());
        chk("slot", slot, exp_slot);
        chk("in_ready", in_ready, rdy);
        for (int i = 0; i < 4; i++) begin
            if (occ[i] && ordy[i]) occ[i] = 1'b0;
        end
        if (acc) begin
            occ[tgt] = 1'b1;
            q[tgt].push_back(d);
        end
        if (au) begin
            if (acc) exp_slot = (tgt + 1) % 4;
            else if (sy) exp_slot = 0;
        end
    endtask

    // Monitor: every beat handed to a consumer must match the scoreboard head.
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_ch%0d: got %0h expected no beat",
                                 i, chan_data(i));
                    end else begin
                        chk($sformatf("data_ch%0d", i), chan_data(i),
                            q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        model_clear();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        auto_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_slot", slot, 2'd0);
        chk("rst_a", out_a, 8'h00);
        chk("rst_b", out_b, 8'h00);
        chk("rst_c", out_c, 8'h00);
        chk("rst_d", out_d, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1, 8'h11, 1, 2'd0, 0, 4'b0000);
        cycle(0, 8'h00, 1, 2'd0, 0, 4'b0000);
        chk("first_a", out_a, 8'h11);

        cycle(0, 8'h00, 1, 2'd0, 1, 4'b1111);
        for (int k = 1; k <= 5; k++) begin
            cycle(1, 8'(k * 16), 1, 2'd0, 0, 4'b1111);
        end
        cycle(0, 8'h00, 1, 2'd0, 0, 4'b1111);
        chk("rr_a", out_a, 8'h50);
        chk("rr_d", out_d, 8'h40);

        cycle(1, 8'hA5, 0, 2'd2, 0, 4'b0000);
        cycle(0, 8'h00, 0, 2'd0, 0, 4'b0000);
        chk("sel_c", out_c, 8'hA5);
        cycle(0, 8'h00, 0, 2'd0, 0, 4'b1111);

        cycle(1, 8'h02, 0, 2'd1, 0, 4'b1101);
        cycle(1, 8'h77, 1, 2'd0, 0, 4'b1101);
        cycle(1, 8'h77, 1, 2'd0, 0, 4'b1111);
        cycle(0, 8'h00, 1, 2'd0, 0, 4'b0000);
        chk("bp_b", out_b, 8'h77);

        cycle(0, 8'h00, 1, 2'd0, 0, 4'b1111);
        cycle(1, 8'h99, 1, 2'd0, 1, 4'b1111);
        cycle(0, 8'h00, 1, 2'd0, 1, 4'b1111);
        cycle(0, 8'h00, 1, 2'd0, 0, 4'b1111);
        chk("sync_a", out_a, 8'h99);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(3, 0) != 0, 8'($urandom),
                  $urandom_range(3, 0) != 0, 2'($urandom),
                  $urandom_range(7, 0) == 0, 4'($urandom));
        end

        cycle(0, 8'h00, 0, 2'd0, 0, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 8'(8'hC0 + k), 0, 2'(k), 0, 4'b0000);
        end
        cycle(0, 8'h00, 0, 2'd0, 0, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 4'b0000);
        chk("async_d", out_d, 8'h00);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 8'h5A, 1, 2'd3, 0, 4'b0000);
        cycle(0, 8'h00, 1, 2'd0, 0, 4'b0000);
        chk("post_rst_a", out_a, 8'h5A);

`ifdef TDM_DEMUX_BEAT_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("cnt_rst", cnt_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cycle(1, 8'(k), 0, 2'd0, 0, 4'b1111);
        end
        cycle(0, 8'h00, 0, 2'd0, 0, 4'b1111);
        chk("cnt_sat_a", cnt_a, 8'd255);
        chk("cnt_b", cnt_b, 8'd0);
`endif

        cycle(0, 8'h00, 0, 2'd0, 0, 4'b1111);
        cycle(0, 8'h00, 0, 2'd0, 0, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_empty_ch%0d", i), q[i].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
